// File: rtl/spread_encoder_if.sv
// Byte-in / chip-out bundle for the spreading encoder.
// The master drives chip_en and the byte handshake; the slave (encoder) drives the chip stream.
interface spread_encoder_if #(
    parameter int unsigned DATA_W = 8
);
    logic              chip_en;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              chip_out;
    logic              chip_valid;
    logic              sym_start;
    logic              pn_epoch;
    logic              underrun;

    modport master (
        output chip_en, s_data, s_valid,
        input  s_ready, chip_out, chip_valid, sym_start, pn_epoch, underrun
    );

    modport slave (
        input  chip_en, s_data, s_valid,
        output s_ready, chip_out, chip_valid, sym_start, pn_epoch, underrun
    );
endinterface

// File: rtl/spread_encoder.sv
// DSSS spreader: bytes are serialised MSB-first and each bit is XORed with a free-running
// Fibonacci LFSR over CHIPS_PER_BIT chips, one chip per chip_en strobe.
module spread_encoder #(
    parameter int unsigned       DATA_W        = 8,
    parameter int unsigned       CHIPS_PER_BIT = 127,
    parameter int unsigned       LFSR_W        = 7,
    parameter logic [LFSR_W-1:0] LFSR_TAPS     = 7'b1100000,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 7'h7F
) (
    input logic             clk,
    input logic             rst_n,
    spread_encoder_if.slave bus
);
    localparam int unsigned     CntW    = (CHIPS_PER_BIT > 1) ? $clog2(CHIPS_PER_BIT) : 1;
    localparam int unsigned     IdxW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CHIPS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxTop  = IdxW'(DATA_W - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              hold_full_q, hold_full_d;
    logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
    logic [CntW-1:0]   chip_cnt_q, chip_cnt_d;
    logic              chip_out_q, chip_out_d;
    logic              chip_valid_q, chip_valid_d;
    logic              sym_start_q, sym_start_d;
    logic              pn_epoch_q, pn_epoch_d;
    logic              underrun_q, underrun_d;

    logic pn, accept, last_chip, last_bit, load;

    assign pn        = lfsr_q[LFSR_W-1];
    assign accept    = bus.s_valid & ~hold_full_q;
    assign last_chip = (state_q == StSend) && (chip_cnt_q == CntLast);
    assign last_bit  = last_chip && (bit_idx_q == '0);
    assign load      = bus.chip_en & hold_full_q & ((state_q == StIdle) | last_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lfsr_q       <= LFSR_SEED;
            hold_q       <= '0;
            shreg_q      <= '0;
            hold_full_q  <= 1'b0;
            bit_idx_q    <= '0;
            chip_cnt_q   <= '0;
            chip_out_q   <= 1'b0;
            chip_valid_q <= 1'b0;
            sym_start_q  <= 1'b0;
            pn_epoch_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            hold_q       <= hold_d;
            shreg_q      <= shreg_d;
            hold_full_q  <= hold_full_d;
            bit_idx_q    <= bit_idx_d;
            chip_cnt_q   <= chip_cnt_d;
            chip_out_q   <= chip_out_d;
            chip_valid_q <= chip_valid_d;
            sym_start_q  <= sym_start_d;
            pn_epoch_q   <= pn_epoch_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        chip_cnt_d  = chip_cnt_q;
        hold_full_d = (hold_full_q & ~load) | accept;
        hold_d      = accept ? bus.s_data : hold_q;
        if (bus.chip_en) begin
            // A stuck all-zero register would lock the PN at 0; reload the seed instead.
            lfsr_d = (lfsr_q == '0) ? LFSR_SEED
                                    : {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
            unique case (state_q)
                StIdle: begin
                    if (hold_full_q) begin
                        // This strobe already emits chip 0 of the new byte.
                        state_d    = StSend;
                        shreg_d    = hold_q;
                        bit_idx_d  = IdxTop;
                        chip_cnt_d = CntW'(1);
                    end
                end
                StSend: begin
                    if (last_chip) begin
                        chip_cnt_d = '0;
                        if (bit_idx_q != '0) begin
                            bit_idx_d = bit_idx_q - IdxW'(1);
                        end else if (hold_full_q) begin
                            shreg_d   = hold_q;
                            bit_idx_d = IdxTop;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        chip_cnt_d = chip_cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        chip_out_d   = chip_out_q;
        chip_valid_d = chip_valid_q;
        sym_start_d  = 1'b0;
        pn_epoch_d   = 1'b0;
        underrun_d   = 1'b0;
        if (bus.chip_en) begin
            pn_epoch_d = (lfsr_q == LFSR_SEED);
            unique case (state_q)
                StIdle: begin
                    chip_valid_d = hold_full_q;
                    chip_out_d   = hold_full_q & (hold_q[DATA_W-1] ^ pn);
                    sym_start_d  = hold_full_q;
                end
                StSend: begin
                    chip_valid_d = 1'b1;
                    chip_out_d   = shreg_q[bit_idx_q] ^ pn;
                    sym_start_d  = (chip_cnt_q == '0);
                    underrun_d   = last_bit & ~hold_full_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready    = ~hold_full_q;
    assign bus.chip_out   = chip_out_q;
    assign bus.chip_valid = chip_valid_q;
    assign bus.sym_start  = sym_start_q;
    assign bus.pn_epoch   = pn_epoch_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_spread_encoder.sv
// Randomized bench for spread_encoder: a queue/array-level model predicts every chip slot,
// and a majority-vote despreader rebuilds the bytes from the DUT's chip stream.
module tb_spread_encoder;
    localparam int unsigned DW         = 8;
    localparam int unsigned CPB        = 4;
    localparam int unsigned BYTE_CHIPS = DW * CPB;
    localparam int unsigned PERIOD     = 127;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spread_encoder_if #(.DATA_W(DW)) bus ();

    spread_encoder #(
        .DATA_W       (DW),
        .CHIPS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // m-sequence of x^7+x^6+1 from an all-ones start: s[n+7] = s[n] ^ s[n+1]
    bit pn_seq[PERIOD];
    int phase;

    logic [7:0] pending[$];
    logic [7:0] cur;
    bit         active;
    int         idx;
    bit         exp_out, exp_valid;

    logic [7:0] tx_q[$];
    logic [7:0] sent[$];
    logic [7:0] rx[$];
    int         rx_acc, rx_chips, rx_bits;
    logic [7:0] rx_byte;

    int sv_prob, per_min, per_max, gap_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model(input bit ce, input bit hs, input logic [7:0] d);
        bit pn, e_sym, e_epoch, e_under;
        pn      = 1'b0;
        e_sym   = 1'b0;
        e_epoch = 1'b0;
        e_under = 1'b0;
        if (ce) begin
            pn      = pn_seq[phase];
            e_epoch = (phase == 0);
            phase   = (phase + 1) % PERIOD;
            if (!active && pending.size() > 0) begin
                cur    = pending.pop_front();
                active = 1'b1;
                idx    = 0;
            end
            if (active) begin
                exp_valid = 1'b1;
                exp_out   = cur[DW-1-idx/CPB] ^ pn;
                e_sym     = (idx % CPB == 0);
                idx++;
                if (idx == BYTE_CHIPS) begin
                    if (pending.size() > 0) begin
                        cur = pending.pop_front();
                        idx = 0;
                    end else begin
                        active  = 1'b0;
                        e_under = 1'b1;
                    end
                end
            end else begin
                exp_valid = 1'b0;
                exp_out   = 1'b0;
            end
            if (bus.chip_valid === 1'b1) begin
                rx_acc += int'(bus.chip_out ^ pn);
                rx_chips++;
                if (rx_chips == CPB) begin
                    rx_byte  = {rx_byte[6:0], (2 * rx_acc > CPB)};
                    rx_acc   = 0;
                    rx_chips = 0;
                    rx_bits++;
                    if (rx_bits == DW) begin
                        rx.push_back(rx_byte);
                        rx_bits = 0;
                    end
                end
            end
        end
        if (hs) pending.push_back(d);
        check("chip_valid", bus.chip_valid, exp_valid);
        check("chip_out", bus.chip_out, exp_out);
        check("sym_start", bus.sym_start, e_sym);
        check("pn_epoch", bus.pn_epoch, e_epoch);
        check("underrun", bus.underrun, e_under);
        check("s_ready", bus.s_ready, pending.size() == 0);
    endtask

    // Called at a negedge; drives one clock of stimulus and checks the result one negedge later.
    task automatic cycle();
        bit         ce, sv, hs;
        logic [7:0] d;
        ce = 1'b0;
        if (gap_cnt == 0) begin
            ce      = 1'b1;
            gap_cnt = $urandom_range(per_max, per_min) - 1;
        end else begin
            gap_cnt--;
        end
        sv = (tx_q.size() > 0) && ($urandom_range(99, 0) < sv_prob);
        d  = sv ? tx_q[0] : 8'($urandom);
        hs = sv && (bus.s_ready === 1'b1);
        bus.chip_en = ce;
        bus.s_valid = sv;
        bus.s_data  = d;
        if (hs) begin
            void'(tx_q.pop_front());
            sent.push_back(d);
        end
        @(negedge clk);
        model(ce, hs, d);
    endtask

    task automatic do_reset();
        bus.chip_en = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst_n       = 1'b0;
        #1;
        check("rst_chip_out", bus.chip_out, 0);
        check("rst_chip_valid", bus.chip_valid, 0);
        check("rst_sym_start", bus.sym_start, 0);
        check("rst_pn_epoch", bus.pn_epoch, 0);
        check("rst_underrun", bus.underrun, 0);
        check("rst_s_ready", bus.s_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pending.delete();
        tx_q.delete();
        sent.delete();
        rx.delete();
        active    = 1'b0;
        idx       = 0;
        phase     = 0;
        exp_out   = 1'b0;
        exp_valid = 1'b0;
        rx_acc    = 0;
        rx_chips  = 0;
        rx_bits   = 0;
        rx_byte   = '0;
        gap_cnt   = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((tx_q.size() > 0 || active || pending.size() > 0) && n < limit) begin
            cycle();
            n++;
        end
        check("drain_bound", n < limit, 1);
        run_cycles(12);
    endtask

    task automatic check_rx();
        check("rx_count", rx.size(), sent.size());
        foreach (sent[i]) begin
            if (i < rx.size()) check("rx_byte", rx[i], sent[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) pn_seq[i] = 1'b1;
        for (int i = 7; i < PERIOD; i++) pn_seq[i] = pn_seq[i-7] ^ pn_seq[i-6];
        bus.chip_en = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        sv_prob     = 100;
        per_min     = 4;
        per_max     = 4;

        // Idle PN: no data, epoch every 127 strobes.
        @(negedge clk);
        do_reset();
        run_cycles(2 * PERIOD * 4 + 8);

        // Single 0x80 straight after reset, then underrun.
        do_reset();
        tx_q = '{8'h80};
        drain(2000);
        check_rx();

        // Three bytes with s_valid held: back-to-back, no gap chip.
        do_reset();
        per_min = 2;
        per_max = 2;
        tx_q    = '{8'hA5, 8'h3C, 8'hFF};
        drain(2000);
        check_rx();

        // Raw and inverted PN over more than one full period.
        do_reset();
        per_min = 1;
        per_max = 1;
        tx_q    = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        drain(2000);
        check_rx();

        // Reset in the middle of the second byte, then PN restarts from seed.
        do_reset();
        per_min = 2;
        per_max = 2;
        tx_q    = '{8'h11, 8'h22, 8'h33};
        run_cycles(2 * BYTE_CHIPS + 20);
        do_reset();
        per_min = 1;
        per_max = 1;
        run_cycles(5);
        tx_q = '{8'h00};
        drain(2000);
        check_rx();

        // Random traffic with irregular strobes and a toggling s_valid.
        do_reset();
        per_min = 1;
        per_max = 9;
        sv_prob = 50;
        for (int i = 0; i < 40; i++) tx_q.push_back(8'($urandom));
        drain(40000);
        check_rx();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
